// File: rtl/mem_access_if.sv
// Bus and data-memory signal bundle for mem_access_ctrl.
// The slave modport is the controller's view; the master modport is the requester's view.
interface mem_access_if #(
  parameter int N = 17
);
  logic         req_read;
  logic         req_write;
  logic [N-1:0] addr_in;
  logic [N-1:0] wdata_in;
  logic         busy;
  logic         done;
  logic         err;
  logic [N-1:0] rdata_out;
  logic         mem_write_en;
  logic [N-1:0] mem_addr;
  logic [N-1:0] mem_datain;
  logic [11:0]  mem_dataout;

  modport slave (
    input  req_read, req_write, addr_in, wdata_in, mem_dataout,
    output busy, done, err, rdata_out, mem_write_en, mem_addr, mem_datain
  );

  modport master (
    output req_read, req_write, addr_in, wdata_in, mem_dataout,
    input  busy, done, err, rdata_out, mem_write_en, mem_addr, mem_datain
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-port data-memory access controller: one bus read or write at a time,
// with range checking against the 4096-word memory and a one-cycle done pulse.
module mem_access_ctrl #(
  parameter int N      = 17,
  parameter int MEM_AW = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  mem_access_if.slave  bus
);

  localparam int MEM_DW = 12;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ_ADDR,
    READ_CAP,
    DONE
  } state_e;

  state_e       state_q, state_d;
  logic [N-1:0] mem_addr_q, mem_addr_d;
  logic [N-1:0] mem_datain_q, mem_datain_d;
  logic [N-1:0] rdata_q, rdata_d;
  logic         err_q, err_d;
  logic         addr_oor;

  assign addr_oor = |bus.addr_in[N-1:MEM_AW];

  // NOTE: every signal gets its hold value before the case statement, so no
  // path through the block leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    mem_addr_d   = mem_addr_q;
    mem_datain_d = mem_datain_q;
    rdata_d      = rdata_q;
    err_d        = err_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_write || bus.req_read) begin
          if (addr_oor) begin
            // Rejected requests touch neither the memory port nor rdata_out.
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            err_d      = 1'b0;
            mem_addr_d = bus.addr_in;
            if (bus.req_write) begin
              mem_datain_d = bus.wdata_in;
              state_d      = WRITE;
            end else begin
              state_d = READ_ADDR;
            end
          end
        end
      end
      WRITE:     state_d = DONE;
      READ_ADDR: state_d = READ_CAP;
      READ_CAP: begin
        rdata_d = {{(N - MEM_DW){1'b0}}, bus.mem_dataout};
        state_d = DONE;
      end
      DONE:      state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mem_addr_q   <= '0;
      mem_datain_q <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_addr_q   <= mem_addr_d;
      mem_datain_q <= mem_datain_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  // Decoded from the state register so reset drops the write strobe at once.
  assign bus.mem_write_en = (state_q == WRITE);
  assign bus.busy         = (state_q != IDLE);
  assign bus.done         = (state_q == DONE);
  assign bus.err          = (state_q == DONE) && err_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_datain   = mem_datain_q;
  assign bus.rdata_out    = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Self-checking bench for mem_access_ctrl: directed vector table, reset and
// back-to-back corner sequences, then random transactions against a word-level model.
module tb_mem_access_ctrl;

  localparam int N      = 17;
  localparam int MEM_AW = 12;
  localparam int MAX_LAT = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  mem_access_if #(.N(N)) bus ();

  mem_access_ctrl #(.N(N), .MEM_AW(MEM_AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Preloaded memory image: word i holds i-3 (so word 4 holds 1).
  function automatic logic [11:0] preload(input int i);
    return 12'(i - 3);
  endfunction

  // Data-memory model: registered read, write on mem_write_en.
  logic [11:0] mem_w [4096];
  bit          mem_v [4096];
  logic [11:0] mem_idx;
  assign mem_idx = bus.mem_addr[11:0];

  always @(posedge clk) begin
    if (bus.mem_write_en) begin
      mem_w[mem_idx] <= bus.mem_datain[11:0];
      mem_v[mem_idx] <= 1'b1;
    end else begin
      bus.mem_dataout <= mem_v[mem_idx] ? mem_w[mem_idx] : preload(int'(mem_idx));
    end
  end

  int we_cnt   = 0;
  int done_cnt = 0;
  always @(negedge clk) begin
    if (bus.mem_write_en === 1'b1) we_cnt++;
    if (bus.done === 1'b1) done_cnt++;
  end

  // Transaction-level reference: memory contents and last read result.
  logic [11:0]  ref_mem [4096];
  logic [N-1:0] ref_rdata;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model(input bit rd, input bit wr, input logic [N-1:0] a, input logic [N-1:0] d,
                       output int lat, output bit e, output int nw);
    if (a[N-1:MEM_AW] != '0) begin
      lat = 1; e = 1'b1; nw = 0;
    end else if (wr) begin
      lat = 2; e = 1'b0; nw = 1;
      ref_mem[a[11:0]] = d[11:0];
    end else begin
      lat = 3; e = 1'b0; nw = 0;
      ref_rdata = {{(N - 12){1'b0}}, ref_mem[a[11:0]]};
    end
    if (!rd && !wr) lat = 0;
  endtask

  // Issue one request from IDLE; optionally keep junk requests asserted while busy
  // (including across the edge that leaves DONE) to prove they are ignored.
  task automatic run_txn(input bit rd, input bit wr, input bit noise,
                         input logic [N-1:0] a, input logic [N-1:0] d,
                         input int exp_lat, input bit exp_err,
                         input logic [N-1:0] exp_rd, input int exp_wr, input string nm);
    int we0;
    int lat;
    @(negedge clk);
    check({nm, " idle_busy"}, 32'(bus.busy), 32'd0);
    bus.req_read  = rd;
    bus.req_write = wr;
    bus.addr_in   = a;
    bus.wdata_in  = d;
    we0 = we_cnt;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    bus.req_read  = 1'b0;
    bus.req_write = 1'b0;
    if (noise) begin
      bus.req_read  = 1'b1;
      bus.req_write = 1'b1;
      bus.addr_in   = N'($urandom_range(0, 4095));
      bus.wdata_in  = N'($urandom);
    end
    while (bus.done !== 1'b1 && lat < MAX_LAT) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check({nm, " done"},    32'(bus.done),      32'd1);
    check({nm, " latency"}, 32'(lat),           32'(exp_lat));
    check({nm, " err"},     32'(bus.err),       32'(exp_err));
    check({nm, " rdata"},   32'(bus.rdata_out), 32'(exp_rd));
    check({nm, " busy"},    32'(bus.busy),      32'd1);
    check({nm, " writes"},  32'(we_cnt - we0),  32'(exp_wr));
    @(posedge clk);
    @(negedge clk);
    bus.req_read  = 1'b0;
    bus.req_write = 1'b0;
    check({nm, " pulse"},   32'(bus.done),      32'd0);
    check({nm, " back_idle"}, 32'(bus.busy),    32'd0);
  endtask

  task automatic model_txn(input bit rd, input bit wr, input bit noise,
                           input logic [N-1:0] a, input logic [N-1:0] d, input string nm);
    int lat;
    bit e;
    int nw;
    model(rd, wr, a, d, lat, e, nw);
    run_txn(rd, wr, noise, a, d, lat, e, ref_rdata, nw, nm);
  endtask

  typedef struct {
    bit           rd;
    bit           wr;
    logic [N-1:0] addr;
    logic [N-1:0] data;
    int           lat;
    bit           err;
    logic [N-1:0] rdata;
    int           writes;
  } vec_t;

  vec_t vecs [10];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int lat;
    bit e;
    int nw;
    int we0;
    int d0;

    for (int i = 0; i < 4096; i++) ref_mem[i] = preload(i);
    ref_rdata = '0;

    bus.req_read  = 1'b0;
    bus.req_write = 1'b0;
    bus.addr_in   = '0;
    bus.wdata_in  = '0;

    vecs[0] = '{1'b0, 1'b1, 17'd5,       17'h1ABCD, 2, 1'b0, 17'h00000, 1};
    vecs[1] = '{1'b1, 1'b0, 17'd5,       17'h00000, 3, 1'b0, 17'h00BCD, 0};
    vecs[2] = '{1'b1, 1'b0, 17'd4,       17'h00000, 3, 1'b0, 17'h00001, 0};
    vecs[3] = '{1'b1, 1'b1, 17'd68,      17'd9,     2, 1'b0, 17'h00001, 1};
    vecs[4] = '{1'b1, 1'b0, 17'd68,      17'h00000, 3, 1'b0, 17'h00009, 0};
    vecs[5] = '{1'b1, 1'b0, 17'd4096,    17'h00000, 1, 1'b1, 17'h00009, 0};
    vecs[6] = '{1'b0, 1'b1, 17'h1F000,   17'd3,     1, 1'b1, 17'h00009, 0};
    vecs[7] = '{1'b0, 1'b1, 17'd4095,    17'h1FFFF, 2, 1'b0, 17'h00009, 1};
    vecs[8] = '{1'b1, 1'b0, 17'd4095,    17'h00000, 3, 1'b0, 17'h00FFF, 0};
    vecs[9] = '{1'b1, 1'b0, 17'd0,       17'h00000, 3, 1'b0, 17'h00FFD, 0};

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst busy",       32'(bus.busy),         32'd0);
    check("rst done",       32'(bus.done),         32'd0);
    check("rst err",        32'(bus.err),          32'd0);
    check("rst we",         32'(bus.mem_write_en), 32'd0);
    check("rst mem_addr",   32'(bus.mem_addr),     32'd0);
    check("rst mem_datain", 32'(bus.mem_datain),   32'd0);
    check("rst rdata",      32'(bus.rdata_out),    32'd0);
    rst_n = 1'b1;

    // Directed vector table.
    foreach (vecs[i]) begin
      model(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].data, lat, e, nw);
      run_txn(vecs[i].rd, vecs[i].wr, 1'b0, vecs[i].addr, vecs[i].data,
              vecs[i].lat, vecs[i].err, vecs[i].rdata, vecs[i].writes, $sformatf("vec%0d", i));
    end

    // Requests raised while busy (and during DONE) must be ignored.
    model_txn(1'b1, 1'b0, 1'b1, 17'd4, 17'd0, "noisy_read");
    model_txn(1'b0, 1'b1, 1'b1, 17'd7, 17'h0F0F0, "noisy_write");
    model_txn(1'b1, 1'b0, 1'b0, 17'd7, 17'd0, "noisy_readback");

    // req_write held for 6 cycles: accepted at edges 0 and 3 only.
    @(negedge clk);
    bus.req_write = 1'b1;
    bus.addr_in   = 17'd10;
    bus.wdata_in  = 17'd100;
    we0 = we_cnt;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      check($sformatf("held busy edge%0d", k), 32'(bus.busy), 32'((k % 3) != 2));
    end
    bus.req_write = 1'b0;
    check("held writes", 32'(we_cnt - we0), 32'd2);
    ref_mem[10] = 12'd100;
    model_txn(1'b1, 1'b0, 1'b0, 17'd10, 17'd0, "held_readback");

    // Reset in the middle of WRITE to addr 2.
    @(negedge clk);
    bus.req_write = 1'b1;
    bus.addr_in   = 17'd2;
    bus.wdata_in  = 17'd7;
    @(posedge clk);
    #1;
    bus.req_write = 1'b0;
    d0 = done_cnt;
    we0 = we_cnt;
    check("rstw we before", 32'(bus.mem_write_en), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rstw we",         32'(bus.mem_write_en), 32'd0);
    check("rstw busy",       32'(bus.busy),         32'd0);
    check("rstw done",       32'(bus.done),         32'd0);
    check("rstw err",        32'(bus.err),          32'd0);
    check("rstw mem_addr",   32'(bus.mem_addr),     32'd0);
    check("rstw mem_datain", 32'(bus.mem_datain),   32'd0);
    check("rstw rdata",      32'(bus.rdata_out),    32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ref_rdata = '0;
    check("rstw no done", 32'(done_cnt - d0), 32'd0);
    check("rstw no write", 32'(we_cnt - we0), 32'd0);
    model_txn(1'b1, 1'b0, 1'b0, 17'd2, 17'd0, "rstw_addr2");

    // Reset while in READ_CAP abandons the read.
    @(negedge clk);
    bus.req_read = 1'b1;
    bus.addr_in  = 17'd5;
    @(posedge clk);
    #1;
    bus.req_read = 1'b0;
    @(posedge clk);
    #1;
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("rstr rdata", 32'(bus.rdata_out), 32'd0);
    check("rstr busy",  32'(bus.busy),      32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    ref_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rstr no done",   32'(done_cnt - d0), 32'd0);
    check("rstr rdata kept", 32'(bus.rdata_out), 32'd0);

    // Randomized transactions against the reference model.
    for (int t = 0; t < 60; t++) begin
      bit rd;
      bit wr;
      logic [N-1:0] a;
      logic [N-1:0] d;
      rd = 1'($urandom);
      wr = 1'($urandom);
      if (!rd && !wr) rd = 1'b1;
      if ($urandom_range(0, 5) == 0)
        a = {5'($urandom_range(1, 31)), 12'($urandom)};
      else
        a = {5'b0, 12'($urandom_range(0, 15))};
      d = N'($urandom);
      model_txn(rd, wr, 1'($urandom), a, d, $sformatf("rnd%0d", t));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
